// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose
//   Stall/forward unit for the D stage of a 5-stage MIPS pipeline. The decoder
//   supplies, for the instruction currently in D, the cycles until each source
//   register is needed (Tuse) and the cycles until its own result exists (Tnew).
//   The unit tracks the destination of every in-flight instruction for DEPTH
//   stages after D, and raises a stall when a source would be consumed before
//   its producer has it. It also picks a forwarding source per read port and
//   runs a busy counter for the multi-cycle mult/div unit. While that counter
//   runs, any HI/LO user waits in D.
//
// Flow control
//   D is a single-entry holding stage. An instruction in D leaves it (issues)
//   on a rising edge only when d_valid=1, stall=0 and flush=0. Whenever it does
//   not issue, a bubble (addr 0, tnew 0) enters E and D keeps its contents.
//   flush outranks issue. stall is still reported during flush, and the PC
//   logic upstream decides what to do with it.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high; clears all state
//   d_valid     in   D holds a real instruction
//   d_rs_addr   in   GRF read port 1 address
//   d_rs_tuse   in   cycles until the rs value is needed; all-ones = unused
//   d_rt_addr   in   GRF read port 2 address
//   d_rt_tuse   in   as d_rs_tuse, for rt
//   d_wr_addr   in   destination register; 0 = no write
//   d_wr_tnew   in   cycles after entering E until the result is available
//   d_md_use    in   instruction reads or writes HI/LO
//   d_md_start  in   00 none, 01 mult, 10 div, 11 reserved (treated as none)
//   flush       in   kill the D instruction this cycle
//   stall       out  freeze PC and D register (combinational)
//   fwd_rs_sel  out  0 = GRF value, k = forward from in-flight slot k
//   fwd_rt_sel  out  as fwd_rs_sel, for rt
//   md_busy     out  mult/div unit busy (decoded from the count register)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int TNEW_W   = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [4:0]        d_rs_addr,
  input  logic [TNEW_W-1:0] d_rs_tuse,
  input  logic [4:0]        d_rt_addr,
  input  logic [TNEW_W-1:0] d_rt_tuse,
  input  logic [4:0]        d_wr_addr,
  input  logic [TNEW_W-1:0] d_wr_tnew,
  input  logic              d_md_use,
  input  logic [1:0]        d_md_start,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);

  // The counter must hold the longer of the two latencies.
  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // In-flight writer slots; index 1 is E, DEPTH is the oldest tracked stage.
  logic [4:0]        slot_addr [1:DEPTH];
  logic [TNEW_W-1:0] slot_tnew [1:DEPTH];

  logic [CNT_W-1:0]  md_cnt;

  logic              issue;
  logic              md_stall;

  // Per read port lookup results; index 0 = rs, 1 = rt.
  logic [4:0]        rd_addr [2];
  logic [TNEW_W-1:0] rd_tuse [2];
  logic [1:0]        rd_hit;
  logic [SEL_W-1:0]  rd_slot [2];
  logic [TNEW_W-1:0] rd_tnew [2];
  logic [1:0]        hazard;
  logic [SEL_W-1:0]  rd_fwd  [2];

  assign rd_addr[0] = d_rs_addr;
  assign rd_addr[1] = d_rt_addr;
  assign rd_tuse[0] = d_rs_tuse;
  assign rd_tuse[1] = d_rt_tuse;

  // ---------------------------------------------------------------------------
  // Slot lookup. The loop runs oldest to youngest, so the last hit written is
  // the youngest writer, which shadows any older writer of the same register.
  // Register 0 is hard-wired and never matches.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_hit[p]  = 1'b0;
      rd_slot[p] = '0;
      rd_tnew[p] = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if ((rd_addr[p] != 5'd0) && (slot_addr[k] == rd_addr[p])) begin
          rd_hit[p]  = 1'b1;
          rd_slot[p] = SEL_W'(k);
          rd_tnew[p] = slot_tnew[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard and forward decode. A producer whose tnew is still above the
  // consumer's tuse cannot deliver in time, so D stalls. A producer with
  // tnew 0 already holds its result and is forwarded directly. For
  // 0 < tnew <= tuse the value is not ready yet but will be before it is
  // needed, so D reports GRF here and a later stage's mux picks up the
  // forward.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hazard[p] = rd_hit[p] && (rd_tnew[p] > rd_tuse[p]);
      rd_fwd[p] = (rd_hit[p] && (rd_tnew[p] == '0)) ? rd_slot[p] : '0;
    end
  end

  assign fwd_rs_sel = rd_fwd[0];
  assign fwd_rt_sel = rd_fwd[1];

  // The counter loads as the start instruction issues, so no start is ever
  // pending in E uncounted; md_busy alone covers the HI/LO interlock.
  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_md_use & md_busy;

  assign stall = d_valid & (hazard[0] | hazard[1] | md_stall);
  assign issue = d_valid & ~stall & ~flush;

  // ---------------------------------------------------------------------------
  // Slot shift register. E receives the issuing instruction or a bubble; older
  // slots age by one cycle, with tnew saturating at 0. The oldest slot drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_addr[k] <= '0;
        slot_tnew[k] <= '0;
      end
    end else begin
      if (issue) begin
        slot_addr[1] <= d_wr_addr;
        slot_tnew[1] <= d_wr_tnew;
      end else begin
        slot_addr[1] <= '0;
        slot_tnew[1] <= '0;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        slot_addr[k] <= slot_addr[k-1];
        slot_tnew[k] <= (slot_tnew[k-1] == '0) ? '0 : slot_tnew[k-1] - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mult/div busy counter. A start only counts when its instruction actually
  // issues; a flushed or stalled start is ignored. Code 11 is treated as none.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (issue && (d_md_start == 2'b01)) begin
      md_cnt <= CNT_W'(MULT_CYC);
    end else if (issue && (d_md_start == 2'b10)) begin
      md_cnt <= CNT_W'(DIV_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule
